// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg -- shared definitions for the memory stage.
//   Opcode encodings, FSM state encoding, access-size codes and small
//   decode helpers used by mem_stage and mem_load_ext.
package mem_stage_pkg;

  // Memory opcodes; any other 5-bit code is a non-memory pass-through.
  localparam logic [4:0] OP_NOP = 5'h00;
  localparam logic [4:0] OP_LB  = 5'h01;
  localparam logic [4:0] OP_LH  = 5'h02;
  localparam logic [4:0] OP_LW  = 5'h03;
  localparam logic [4:0] OP_LBU = 5'h04;
  localparam logic [4:0] OP_LHU = 5'h05;
  localparam logic [4:0] OP_SB  = 5'h06;
  localparam logic [4:0] OP_SH  = 5'h07;
  localparam logic [4:0] OP_SW  = 5'h08;

  // Access size codes (number of bytes = 1, 2, 4).
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    XFER = 3'd2,
    LAST = 3'd3,
    DONE = 3'd4
  } state_e;

  function automatic logic is_mem_op(input logic [4:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
      OP_SB, OP_SH, OP_SW: is_mem_op = 1'b1;
      default:             is_mem_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_store_op(input logic [4:0] op);
    case (op)
      OP_SB, OP_SH, OP_SW: is_store_op = 1'b1;
      default:             is_store_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_signed_op(input logic [4:0] op);
    case (op)
      OP_LB, OP_LH: is_signed_op = 1'b1;
      default:      is_signed_op = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] op_size(input logic [4:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: op_size = SIZE_B;
      OP_LH, OP_LHU, OP_SH: op_size = SIZE_H;
      default:              op_size = SIZE_W;
    endcase
  endfunction

  // Index of the final byte of an access (N-1).
  function automatic logic [1:0] size_last_idx(input logic [1:0] sz);
    case (sz)
      SIZE_B:  size_last_idx = 2'd0;
      SIZE_H:  size_last_idx = 2'd1;
      default: size_last_idx = 2'd3;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      SIZE_H:  is_misaligned = a[0];
      SIZE_W:  is_misaligned = (a != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

  // Little-endian byte lane select.
  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    byte_sel = w[7:0];
      2'd1:    byte_sel = w[15:8];
      2'd2:    byte_sel = w[23:16];
      default: byte_sel = w[31:24];
    endcase
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// mem_load_ext -- load byte assembly and sign/zero extension (combinational).
//   asm_in    : partially assembled load word
//   byte_in   : byte returned by the RAM
//   cap_en    : merge byte_in into the assembly this cycle
//   cap_idx   : little-endian lane for byte_in
//   size_in   : access size code (SIZE_B/H/W)
//   signed_in : 1 = sign-extend, 0 = zero-extend
//   asm_out   : assembly after merge (next value of the assembly register)
//   ext_out   : asm_out extended to 32 bits according to size/signedness
module mem_load_ext
  import mem_stage_pkg::*;
(
  input  logic [31:0] asm_in,
  input  logic [7:0]  byte_in,
  input  logic        cap_en,
  input  logic [1:0]  cap_idx,
  input  logic [1:0]  size_in,
  input  logic        signed_in,
  output logic [31:0] asm_out,
  output logic [31:0] ext_out
);

  // Merge the incoming byte into its lane.
  always_comb begin
    asm_out = asm_in;
    if (cap_en) begin
      case (cap_idx)
        2'd0:    asm_out[7:0]   = byte_in;
        2'd1:    asm_out[15:8]  = byte_in;
        2'd2:    asm_out[23:16] = byte_in;
        default: asm_out[31:24] = byte_in;
      endcase
    end else begin
      asm_out = asm_in;
    end
  end

  // Extend the merged value to a full word.
  always_comb begin
    ext_out = asm_out;
    case (size_in)
      SIZE_B:  ext_out = {{24{signed_in & asm_out[7]}}, asm_out[7:0]};
      SIZE_H:  ext_out = {{16{signed_in & asm_out[15]}}, asm_out[15:0]};
      default: ext_out = asm_out;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage -- pipeline memory stage with a byte-wide RAM port.
//   Loads/stores of 1, 2 or 4 bytes are performed one byte per cycle,
//   little-endian, after winning the shared RAM arbiter. Non-memory ops
//   and bubbles pass straight through to the writeback registers.
//
// Ports:
//   clk_in, rst_in (async, active-low), rdy_in (global enable / freeze)
//   we_in, w_addr_in, w_data_in       : writeback request / store data
//   opcode_in, mem_addr_in, busy_in   : operation, byte address, bubble flag
//   ram_req / ram_gnt                 : arbiter handshake
//   ram_addr, ram_dout, ram_wr, ram_din : byte RAM (read data one cycle late)
//   wb_we, wb_w_addr, wb_w_data       : registered writeback result
//   stall_req                         : holds upstream while an access runs
//   misalign_out                      : misalignment trap pulse (only when
//                                       MEM_MISALIGN_TRAP_EN is defined)
//
// Build option: define MEM_MISALIGN_TRAP_EN to trap misaligned H/W accesses
// instead of performing them bytewise.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        we_in,
  input  logic [4:0]  w_addr_in,
  input  logic [31:0] w_data_in,
  input  logic [4:0]  opcode_in,
  input  logic [31:0] mem_addr_in,
  input  logic        busy_in,
  output logic        ram_req,
  input  logic        ram_gnt,
  output logic [31:0] ram_addr,
  output logic [7:0]  ram_dout,
  output logic        ram_wr,
  input  logic [7:0]  ram_din,
  output logic        wb_we,
  output logic [4:0]  wb_w_addr,
  output logic [31:0] wb_w_data,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic        misalign_out,
`endif
  output logic        stall_req
);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  size_q, size_d;
  logic        store_q, store_d;
  logic        signed_q, signed_d;
  logic [31:0] data_q, data_d;
  logic [31:0] asm_q, asm_d;
  logic        ram_req_q, ram_req_d;
  logic [31:0] ram_addr_q, ram_addr_d;
  logic [7:0]  ram_dout_q, ram_dout_d;
  logic        ram_wr_q, ram_wr_d;
  logic        wb_we_q, wb_we_d;
  logic [4:0]  wb_w_addr_q, wb_w_addr_d;
  logic [31:0] wb_w_data_q, wb_w_data_d;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_q, misalign_d;
`endif

  logic        accept;
  logic [1:0]  last_idx;
  logic        cap_en;
  logic [1:0]  cap_idx;
  logic [31:0] asm_next;
  logic [31:0] load_ext;

  assign accept   = rdy_in & (state_q == IDLE) & is_mem_op(opcode_in) & ~busy_in;
  assign last_idx = size_last_idx(size_q);

  // Stall is combinational so the upstream register holds in the accept cycle.
  assign stall_req = accept | (state_q == REQ) | (state_q == XFER) | (state_q == LAST);

  // A load byte arrives one cycle after its address: in XFER we capture the
  // previous byte, in LAST the final one.
  assign cap_en  = ((state_q == XFER) & (cnt_q != 2'd0)) | (state_q == LAST);
  assign cap_idx = (state_q == LAST) ? last_idx : (cnt_q - 2'd1);

  mem_load_ext u_load_ext (
    .asm_in    (asm_q),
    .byte_in   (ram_din),
    .cap_en    (cap_en),
    .cap_idx   (cap_idx),
    .size_in   (size_q),
    .signed_in (signed_q),
    .asm_out   (asm_next),
    .ext_out   (load_ext)
  );

  // Next-state and next-output logic; every register holds when rdy_in is low.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    size_d      = size_q;
    store_d     = store_q;
    signed_d    = signed_q;
    data_d      = data_q;
    asm_d       = asm_q;
    ram_req_d   = ram_req_q;
    ram_addr_d  = ram_addr_q;
    ram_dout_d  = ram_dout_q;
    ram_wr_d    = ram_wr_q;
    wb_we_d     = wb_we_q;
    wb_w_addr_d = wb_w_addr_q;
    wb_w_data_d = wb_w_data_q;
`ifdef MEM_MISALIGN_TRAP_EN
    misalign_d  = misalign_q;
`endif
    if (rdy_in) begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            size_d      = op_size(opcode_in);
            store_d     = is_store_op(opcode_in);
            signed_d    = is_signed_op(opcode_in);
            data_d      = w_data_in;
            asm_d       = 32'h0000_0000;
            cnt_d       = 2'd0;
            wb_we_d     = 1'b0;
            wb_w_addr_d = w_addr_in;
`ifdef MEM_MISALIGN_TRAP_EN
            if (is_misaligned(op_size(opcode_in), mem_addr_in[1:0])) begin
              state_d    = DONE;
              misalign_d = 1'b1;
            end else begin
              state_d    = REQ;
              ram_req_d  = 1'b1;
              ram_addr_d = mem_addr_in;
            end
`else
            state_d    = REQ;
            ram_req_d  = 1'b1;
            ram_addr_d = mem_addr_in;
`endif
          end else begin
            // Pass-through or bubble: one-cycle registered copy.
            wb_we_d     = we_in & ~busy_in;
            wb_w_addr_d = w_addr_in;
            wb_w_data_d = w_data_in;
          end
        end
        REQ: begin
          if (ram_gnt) begin
            state_d    = XFER;
            cnt_d      = 2'd0;
            ram_wr_d   = store_q;
            ram_dout_d = store_q ? data_q[7:0] : 8'h00;
          end else begin
            state_d = REQ;
          end
        end
        XFER: begin
          // Grant is not re-checked here: the arbiter never preempts.
          asm_d = asm_next;
          if (cnt_q == last_idx) begin
            if (store_q) begin
              state_d    = DONE;
              ram_req_d  = 1'b0;
              ram_wr_d   = 1'b0;
              ram_dout_d = 8'h00;
              wb_we_d    = 1'b0;
            end else begin
              state_d = LAST;
            end
          end else begin
            cnt_d      = cnt_q + 2'd1;
            ram_addr_d = ram_addr_q + 32'd1;  // wraps modulo 2^32
            ram_dout_d = store_q ? byte_sel(data_q, cnt_q + 2'd1) : 8'h00;
          end
        end
        LAST: begin
          asm_d       = asm_next;
          state_d     = DONE;
          ram_req_d   = 1'b0;
          wb_we_d     = 1'b1;
          wb_w_data_d = load_ext;
        end
        DONE: begin
          // Inputs are ignored here; the next op is taken from IDLE.
          state_d = IDLE;
          cnt_d   = 2'd0;
          wb_we_d = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
          misalign_d = 1'b0;
`endif
        end
        default: begin
          state_d   = IDLE;
          ram_req_d = 1'b0;
          ram_wr_d  = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      size_q      <= SIZE_B;
      store_q     <= 1'b0;
      signed_q    <= 1'b0;
      data_q      <= 32'h0000_0000;
      asm_q       <= 32'h0000_0000;
      ram_req_q   <= 1'b0;
      ram_addr_q  <= 32'h0000_0000;
      ram_dout_q  <= 8'h00;
      ram_wr_q    <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_w_addr_q <= 5'd0;
      wb_w_data_q <= 32'h0000_0000;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      size_q      <= size_d;
      store_q     <= store_d;
      signed_q    <= signed_d;
      data_q      <= data_d;
      asm_q       <= asm_d;
      ram_req_q   <= ram_req_d;
      ram_addr_q  <= ram_addr_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
      wb_we_q     <= wb_we_d;
      wb_w_addr_q <= wb_w_addr_d;
      wb_w_data_q <= wb_w_data_d;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q  <= misalign_d;
`endif
    end
  end

  assign ram_req   = ram_req_q;
  assign ram_addr  = ram_addr_q;
  assign ram_dout  = ram_dout_q;
  assign ram_wr    = ram_wr_q;
  assign wb_we     = wb_we_q;
  assign wb_w_addr = wb_w_addr_q;
  assign wb_w_data = wb_w_data_q;
`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_out = misalign_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage -- directed, table-driven bench for mem_stage with a small
// byte-RAM model (read data one cycle after address, writes logged).
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk_in, rst_in, rdy_in;
  logic        we_in, busy_in;
  logic [4:0]  w_addr_in, opcode_in;
  logic [31:0] w_data_in, mem_addr_in;
  logic        ram_req, ram_gnt, ram_wr;
  logic [31:0] ram_addr;
  logic [7:0]  ram_dout, ram_din;
  logic        wb_we;
  logic [4:0]  wb_w_addr;
  logic [31:0] wb_w_data;
  logic        stall_req;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_out;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0]  mem [0:1023];
  logic [31:0] wlog_addr [0:63];
  logic [7:0]  wlog_data [0:63];
  int          wlog_cyc  [0:63];
  int          wcount = 0;

  mem_stage dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .we_in       (we_in),
    .w_addr_in   (w_addr_in),
    .w_data_in   (w_data_in),
    .opcode_in   (opcode_in),
    .mem_addr_in (mem_addr_in),
    .busy_in     (busy_in),
    .ram_req     (ram_req),
    .ram_gnt     (ram_gnt),
    .ram_addr    (ram_addr),
    .ram_dout    (ram_dout),
    .ram_wr      (ram_wr),
    .ram_din     (ram_din),
    .wb_we       (wb_we),
    .wb_w_addr   (wb_w_addr),
    .wb_w_data   (wb_w_data),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign_out(misalign_out),
`endif
    .stall_req   (stall_req)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // RAM model: registered read (gated by the global enable), write log.
  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    if (rdy_in) ram_din <= mem[ram_addr[9:0]];
    if (ram_wr && wcount < 64) begin
      wlog_addr[wcount] <= ram_addr;
      wlog_data[wcount] <= ram_dout;
      wlog_cyc[wcount]  <= cyc;
      wcount            <= wcount + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs;
    opcode_in = OP_NOP; we_in = 1'b0; busy_in = 1'b0;
    w_addr_in = 5'd0; w_data_in = 32'h0; mem_addr_in = 32'h0;
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    int          gdly;
    int          nbytes;
    logic        store;
    logic [31:0] exp_data;
    logic        exp_we;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int n;
    int w0;
    vec_t t;

    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[10'h100] = 8'h78; mem[10'h101] = 8'h56; mem[10'h102] = 8'h34; mem[10'h103] = 8'h12;
    mem[10'h104] = 8'hAA; mem[10'h105] = 8'hBB;
    mem[10'h003] = 8'h80;
    mem[10'h010] = 8'h34; mem[10'h011] = 8'h92;
    mem[10'h3FF] = 8'hCD; mem[10'h000] = 8'hEF;

    //                op      addr           wd            gdly n  st    exp_data       we    lat
    vecs.push_back('{OP_LW,  32'h0000_0100, 32'h0,        0,   4, 1'b0, 32'h1234_5678, 1'b1, 5});
    vecs.push_back('{OP_LB,  32'h0000_0003, 32'h0,        0,   1, 1'b0, 32'hFFFF_FF80, 1'b1, 2});
    vecs.push_back('{OP_LBU, 32'h0000_0003, 32'h0,        1,   1, 1'b0, 32'h0000_0080, 1'b1, 2});
    vecs.push_back('{OP_LH,  32'h0000_0010, 32'h0,        3,   2, 1'b0, 32'hFFFF_9234, 1'b1, 3});
    vecs.push_back('{OP_LHU, 32'h0000_0010, 32'h0,        0,   2, 1'b0, 32'h0000_9234, 1'b1, 3});
    vecs.push_back('{OP_LH,  32'h0000_0100, 32'h0,        0,   2, 1'b0, 32'h0000_5678, 1'b1, 3});
    vecs.push_back('{OP_LB,  32'h0000_0101, 32'h0,        2,   1, 1'b0, 32'h0000_0056, 1'b1, 2});
    vecs.push_back('{OP_SW,  32'h0000_0200, 32'hDEADBEEF, 0,   4, 1'b1, 32'h0,         1'b0, 4});
    vecs.push_back('{OP_SB,  32'h0000_0300, 32'h0000_0055, 1,  1, 1'b1, 32'h0,         1'b0, 1});
    vecs.push_back('{OP_SH,  32'h0000_0302, 32'h1234_ABCD, 0,  2, 1'b1, 32'h0,         1'b0, 2});
`ifndef MEM_MISALIGN_TRAP_EN
    vecs.push_back('{OP_LW,  32'h0000_0102, 32'h0,        0,   4, 1'b0, 32'hBBAA_1234, 1'b1, 5});
    vecs.push_back('{OP_LHU, 32'hFFFF_FFFF, 32'h0,        0,   2, 1'b0, 32'h0000_EFCD, 1'b1, 3});
`endif

    // Reset state.
    rst_in = 1'b0; rdy_in = 1'b1; ram_gnt = 1'b0;
    idle_inputs();
    tick; tick;
    chk("rst_wb_we", wb_we, 1'b0);
    chk("rst_wb_w_addr", wb_w_addr, 5'd0);
    chk("rst_wb_w_data", wb_w_data, 32'h0);
    chk("rst_ram_req", ram_req, 1'b0);
    chk("rst_ram_addr", ram_addr, 32'h0);
    chk("rst_ram_dout", ram_dout, 8'h0);
    chk("rst_ram_wr", ram_wr, 1'b0);
    chk("rst_stall", stall_req, 1'b0);
    rst_in = 1'b1;
    tick;

    // Pass-through of a non-memory op.
    opcode_in = OP_NOP; we_in = 1'b1; w_addr_in = 5'd7; w_data_in = 32'hCAFE_F00D;
    #1 chk("pt_stall", stall_req, 1'b0);
    tick;
    chk("pt_wb_we", wb_we, 1'b1);
    chk("pt_wb_addr", wb_w_addr, 5'd7);
    chk("pt_wb_data", wb_w_data, 32'hCAFE_F00D);
    chk("pt_ram_req", ram_req, 1'b0);
    // Bubble carrying a memory opcode.
    opcode_in = OP_LW; busy_in = 1'b1; w_addr_in = 5'd9; w_data_in = 32'h1111_2222;
    #1 chk("bub_stall", stall_req, 1'b0);
    tick;
    chk("bub_wb_we", wb_we, 1'b0);
    chk("bub_wb_data", wb_w_data, 32'h1111_2222);
    chk("bub_ram_req", ram_req, 1'b0);
    // Unknown opcode with we_in low.
    opcode_in = 5'h1F; busy_in = 1'b0; we_in = 1'b0; w_data_in = 32'h3;
    tick;
    chk("unk_wb_we", wb_we, 1'b0);
    chk("unk_stall", stall_req, 1'b0);
    idle_inputs();
    tick;

    // Table of memory operations.
    for (int v = 0; v < vecs.size(); v++) begin
      t = vecs[v];
      w0 = wcount;
      opcode_in = t.op; mem_addr_in = t.addr; w_data_in = t.wd;
      w_addr_in = 5'(v + 1); we_in = 1'b1; busy_in = 1'b0;
      #1 chk("accept_stall", stall_req, 1'b1);
      tick;
      for (int k = 0; k < t.gdly; k++) begin
        chk("wait_ram_req", ram_req, 1'b1);
        chk("wait_ram_addr", ram_addr, t.addr);
        chk("wait_stall", stall_req, 1'b1);
        tick;
      end
      chk("req_ram_req", ram_req, 1'b1);
      chk("req_ram_addr", ram_addr, t.addr);
      ram_gnt = 1'b1;
      tick;
      ram_gnt = 1'b0;
      n = 0;
      while (stall_req && n < 12) begin
        tick;
        n++;
      end
      chk("latency", 32'(n), 32'(t.exp_lat));
      chk("done_wb_we", wb_we, t.exp_we);
      chk("done_ram_req", ram_req, 1'b0);
      if (t.store) begin
        chk("st_count", 32'(wcount - w0), 32'(t.nbytes));
        for (int i = 0; i < t.nbytes && (w0 + i) < wcount; i++) begin
          chk("st_addr", wlog_addr[w0 + i], t.addr + 32'(i));
          chk("st_data", wlog_data[w0 + i], 32'(8'(t.wd >> (8 * i))));
          if (i > 0) chk("st_consec", 32'(wlog_cyc[w0 + i] - wlog_cyc[w0 + i - 1]), 32'd1);
        end
      end else begin
        chk("ld_data", wb_w_data, t.exp_data);
        chk("ld_wb_addr", wb_w_addr, 32'(v + 1));
        chk("ld_no_write", 32'(wcount - w0), 32'd0);
      end
      idle_inputs();
      tick;
      chk("wb_pulse", wb_we, 1'b0);
    end

    // Freeze mid-transfer with rdy_in low.
    opcode_in = OP_LW; mem_addr_in = 32'h100; w_addr_in = 5'd3; we_in = 1'b1;
    tick;
    ram_gnt = 1'b1; tick; ram_gnt = 1'b0;
    tick;
    chk("frz_pre_addr", ram_addr, 32'h101);
    rdy_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("frz_addr", ram_addr, 32'h101);
      chk("frz_req", ram_req, 1'b1);
      chk("frz_stall", stall_req, 1'b1);
    end
    rdy_in = 1'b1;
    n = 0;
    while (stall_req && n < 12) begin
      tick;
      n++;
    end
    chk("frz_latency", 32'(n), 32'd4);
    chk("frz_data", wb_w_data, 32'h1234_5678);
    chk("frz_we", wb_we, 1'b1);
    idle_inputs();
    tick;

    // Reset during the third byte of a store.
    w0 = wcount;
    opcode_in = OP_SW; mem_addr_in = 32'h240; w_data_in = 32'hDEAD_BEEF; w_addr_in = 5'd4;
    tick;
    ram_gnt = 1'b1; tick; ram_gnt = 1'b0;
    tick; tick;
    chk("rstx_wr_b2", ram_wr, 1'b1);
    chk("rstx_addr_b2", ram_addr, 32'h242);
    rst_in = 1'b0;
    idle_inputs();
    #1;
    chk("rstx_ram_wr", ram_wr, 1'b0);
    chk("rstx_ram_req", ram_req, 1'b0);
    chk("rstx_ram_addr", ram_addr, 32'h0);
    chk("rstx_stall", stall_req, 1'b0);
    tick; tick;
    rst_in = 1'b1;
    tick;
    chk("rstx_wcount", 32'(wcount - w0), 32'd2);
    chk("rstx_log0", wlog_addr[w0], 32'h240);
    chk("rstx_log1", wlog_addr[w0 + 1], 32'h241);

`ifdef MEM_MISALIGN_TRAP_EN
    // Misaligned word load traps without touching the RAM.
    w0 = wcount;
    opcode_in = OP_LW; mem_addr_in = 32'h102; w_addr_in = 5'd5; we_in = 1'b1;
    #1 chk("mis_stall", stall_req, 1'b1);
    tick;
    chk("mis_pulse", misalign_out, 1'b1);
    chk("mis_ram_req", ram_req, 1'b0);
    chk("mis_wb_we", wb_we, 1'b0);
    chk("mis_done_stall", stall_req, 1'b0);
    idle_inputs();
    tick;
    chk("mis_pulse_end", misalign_out, 1'b0);
    chk("mis_ram_req2", ram_req, 1'b0);
    chk("mis_no_write", 32'(wcount - w0), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port: clk_in  input  1  single clock, all state on rising edge.
REQ-002 SHALL have port: rst_in  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: rdy_in  input  1  global enable; low freezes all state and outputs.
REQ-004 SHALL have ports: we_in  input  1 / w_addr_in  input  5 / w_data_in  input  32  writeback request from the EX/MEM register.
REQ-005 SHALL have ports: opcode_in  input  5 / mem_addr_in  input  32 / busy_in  input  1  operation code, byte address, bubble flag.
REQ-006 SHALL have ports: ram_req  output  1 / ram_gnt  input  1  request/grant with the memory arbiter shared with fetch.
REQ-007 SHALL have ports: ram_addr  output  32 / ram_dout  output  8 / ram_wr  output  1 / ram_din  input  8  byte-wide RAM; ram_din valid one cycle after address.
REQ-008 SHALL have ports: wb_we  output  1 / wb_w_addr  output  5 / wb_w_data  output  32  registered writeback result.
REQ-009 SHALL have port: stall_req  output  1  holds upstream stages while an access is pending.

Function
REQ-010 Opcodes SHALL be LB, LH, LW, LBU, LHU, SB, SH, SW; every other code is non-memory pass-through.
REQ-011 Pass-through (or busy_in=1 treated as bubble with wb_we=0) SHALL register inputs to wb_* in 1 cycle, stall_req=0.
REQ-012 FSM states SHALL be IDLE, REQ, XFER, LAST, DONE.
REQ-013 IDLE + memory opcode + busy_in=0: latch op/addr/data, go REQ; stall_req SHALL be asserted combinationally in that same cycle.
REQ-014 REQ: ram_req=1; on ram_gnt=1 go XFER; ram_req SHALL stay high through LAST.
REQ-015 XFER SHALL issue byte i at ram_addr=mem_addr+i, i=0..N-1 (N=1/2/4), one byte per cycle, little-endian.
REQ-016 Loads: byte i-1 captured from ram_din while byte i is issued; LAST captures final byte; ram_wr=0 throughout.
REQ-017 Stores: ram_dout = w_data byte i, ram_wr=1 per issued byte; after final byte go DONE directly (no LAST).
REQ-018 LB/LH SHALL sign-extend, LBU/LHU zero-extend; stores SHALL drive wb_we=0.
REQ-019 DONE: wb_* updated, ram_req=0, stall_req=0, next state IDLE; new op accepted no earlier than next cycle.
REQ-020 Load latency from grant SHALL be N+1 cycles to DONE; store latency N cycles.
REQ-021 ram_gnt deassert during XFER/LAST SHALL be ignored (arbiter guarantees non-preemption).
REQ-022 Address increment SHALL wrap modulo 2^32.
REQ-023 rdy_in=0 SHALL freeze FSM, byte counter, assembly register and all outputs, including mid-transfer.

Reset
REQ-024 Reset asserted SHALL force IDLE, counter 0, and all outputs (wb_we, wb_w_addr, wb_w_data, ram_req, ram_addr, ram_dout, ram_wr) to 0 immediately.
REQ-025 Reset mid-transfer SHALL abort the access; no further RAM write after reset assertion.

Configuration
REQ-026 With MEM_MISALIGN_TRAP_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 SHALL skip RAM access, go DONE next cycle with wb_we=0, and pulse output misalign_out (1 bit) for that cycle.
REQ-027 Without MEM_MISALIGN_TRAP_EN: misaligned accesses SHALL complete bytewise normally and misalign_out SHALL not exist.

Structure
REQ-028 Opcode encodings, FSM state encoding and access-size constants SHALL live in the shared defines package.
REQ-029 Load byte-assembly and sign/zero extension SHALL be one sub-module, mem_load_ext.

Verification
REQ-030 LW addr 0x100, RAM bytes 78 56 34 12, gnt immediate -> wb_w_data=0x12345678, wb_we=1, DONE 5 cycles after grant.
REQ-031 LB addr 0x3, byte 0x80 -> 0xFFFFFF80; LBU same -> 0x00000080.
REQ-032 SW 0xDEADBEEF addr 0x200 -> writes EF BE AD DE at 0x200..0x203 in consecutive cycles, wb_we=0.
REQ-033 LH with ram_gnt delayed 3 cycles -> stall_req high throughout, ram_addr stable, result correct after grant.
REQ-034 rst_in low during 3rd byte of SW -> ram_wr=0 immediately, state IDLE, byte 3 never written.
REQ-035 With MEM_MISALIGN_TRAP_EN: LW addr 0x102 -> no ram_req, misalign_out pulse, wb_we=0; without: LW completes bytewise.
